// File: rtl/mac_tx_pkg.sv
// rtl/mac_tx_pkg.sv - shared types and constants for the MAC TX arbiter
package mac_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] MOD_4B = 2'b00;
  localparam logic [1:0] MOD_3B = 2'b01;
  localparam logic [1:0] MOD_2B = 2'b10;
  localparam logic [1:0] MOD_1B = 2'b11;

  localparam int MAX_WORDS_DEFAULT = 380;

  // Bits needed to hold word indices 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_tx_arbiter_if.sv
// rtl/mac_tx_arbiter_if.sv - packet source stream (Avalon-ST style) feeding the arbiter
interface mac_tx_arbiter_if;
  logic [31:0] data;
  logic        sop;
  logic        eop;
  logic [1:0]  mod;
  logic        valid;
  logic        ready;

  modport master (output data, sop, eop, mod, valid, input ready);
  modport slave  (input data, sop, eop, mod, valid, output ready);
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - 2-way round-robin pick; last_grant resets to 1 so source 0 wins the first tie
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt,
  output logic       gnt_vld
);

  logic last_q, last_d;

  always_comb begin
    gnt_vld = |req;
    gnt     = (req == 2'b11) ? ~last_q : req[1];
    last_d  = last_q;
    if (take && gnt_vld) last_d = gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// rtl/mac_tx_arbiter.sv - packet-level round-robin arbiter onto the MAC ff_tx write port
module mac_tx_arbiter
  import mac_tx_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic                ff_tx_clk,
  input  logic                ff_tx_rst_n,
  mac_tx_arbiter_if.slave     s0,
  mac_tx_arbiter_if.slave     s1,
  output logic [31:0]         ff_tx_data,
  output logic                ff_tx_sop,
  output logic                ff_tx_eop,
  output logic                ff_tx_err,
  output logic                ff_tx_wren,
  output logic [1:0]          ff_tx_mod,
  input  logic                ff_tx_rdy,
  output logic [15:0]         pkt_cnt0,
  output logic [15:0]         pkt_cnt1,
  output logic [7:0]          trunc_cnt
);

  localparam int CW = cnt_width(MAX_WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_WORDS - 1);

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic [CW-1:0]   word_cnt_q, word_cnt_d;
  logic            first_q, first_d;
  logic [15:0]     pkt_cnt0_q, pkt_cnt0_d, pkt_cnt1_q, pkt_cnt1_d;
  logic [7:0]      trunc_cnt_q, trunc_cnt_d;

  logic            arb_gnt, arb_vld;
  logic [31:0]     g_data;
  logic            g_valid, g_eop, g_ready;
  logic [1:0]      g_mod;
  logic            limit, xfer;

  rr_arb2 u_rr (
    .clk     (ff_tx_clk),
    .rst_n   (ff_tx_rst_n),
    .req     ({s1.valid & s1.sop, s0.valid & s0.sop}),
    .take    (state_q == IDLE),
    .gnt     (arb_gnt),
    .gnt_vld (arb_vld)
  );

  assign g_data  = grant_q ? s1.data  : s0.data;
  assign g_valid = grant_q ? s1.valid : s0.valid;
  assign g_eop   = grant_q ? s1.eop   : s0.eop;
  assign g_mod   = grant_q ? s1.mod   : s0.mod;
  assign limit   = (word_cnt_q == LAST_IDX);
  assign s0.ready = g_ready & ~grant_q;
  assign s1.ready = g_ready &  grant_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    word_cnt_d  = word_cnt_q;
    first_d     = first_q;
    pkt_cnt0_d  = pkt_cnt0_q;
    pkt_cnt1_d  = pkt_cnt1_q;
    trunc_cnt_d = trunc_cnt_q;
    g_ready     = 1'b0;
    xfer        = 1'b0;
    ff_tx_data  = 32'd0;
    ff_tx_sop   = 1'b0;
    ff_tx_eop   = 1'b0;
    ff_tx_err   = 1'b0;
    ff_tx_wren  = 1'b0;
    ff_tx_mod   = MOD_4B;

    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          grant_d    = arb_gnt;
          word_cnt_d = '0;
          first_d    = 1'b1;
          state_d    = FWD;
        end
      end
      FWD: begin
        ff_tx_data = g_data;
        ff_tx_wren = g_valid;
        g_ready    = ff_tx_rdy;
        ff_tx_sop  = first_q;
        ff_tx_eop  = g_eop | limit;
        ff_tx_mod  = g_eop ? g_mod : MOD_4B;
        ff_tx_err  = limit & ~g_eop;
        xfer       = g_valid & ff_tx_rdy;
        if (xfer) begin
          word_cnt_d = word_cnt_q + CW'(1);
          first_d    = 1'b0;
          if (g_eop) begin
            if (grant_q) pkt_cnt1_d = pkt_cnt1_q + 16'd1;
            else         pkt_cnt0_d = pkt_cnt0_q + 16'd1;
            state_d = IDLE;
          end else if (limit) begin
            if (trunc_cnt_q != 8'hFF) trunc_cnt_d = trunc_cnt_q + 8'd1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Swallow the remainder of a truncated packet up to its own eop.
        g_ready = 1'b1;
        if (g_valid && g_eop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ff_tx_clk or negedge ff_tx_rst_n) begin
    if (!ff_tx_rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      word_cnt_q  <= '0;
      first_q     <= 1'b0;
      pkt_cnt0_q  <= 16'd0;
      pkt_cnt1_q  <= 16'd0;
      trunc_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      word_cnt_q  <= word_cnt_d;
      first_q     <= first_d;
      pkt_cnt0_q  <= pkt_cnt0_d;
      pkt_cnt1_q  <= pkt_cnt1_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign pkt_cnt0  = pkt_cnt0_q;
  assign pkt_cnt1  = pkt_cnt1_q;
  assign trunc_cnt = trunc_cnt_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb/tb_mac_tx_arbiter.sv - scoreboard bench for mac_tx_arbiter (default size and an 8-word variant)
module tb_mac_tx_arbiter;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  mod;
    logic        err;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mac_rdy = 1'b1;
  always #5 clk = ~clk;

  mac_tx_arbiter_if a0 ();
  mac_tx_arbiter_if a1 ();
  mac_tx_arbiter_if t0 ();
  mac_tx_arbiter_if t1 ();

  logic [31:0] m_data, t_data;
  logic        m_sop, m_eop, m_err, m_wren, t_sop, t_eop, t_err, t_wren;
  logic [1:0]  m_mod, t_mod;
  logic [15:0] m_pc0, m_pc1, t_pc0, t_pc1;
  logic [7:0]  m_tc, t_tc;

  mac_tx_arbiter dut (
    .ff_tx_clk(clk), .ff_tx_rst_n(rst_n), .s0(a0), .s1(a1),
    .ff_tx_data(m_data), .ff_tx_sop(m_sop), .ff_tx_eop(m_eop), .ff_tx_err(m_err),
    .ff_tx_wren(m_wren), .ff_tx_mod(m_mod), .ff_tx_rdy(mac_rdy),
    .pkt_cnt0(m_pc0), .pkt_cnt1(m_pc1), .trunc_cnt(m_tc)
  );

  mac_tx_arbiter #(.MAX_WORDS(8)) dut_t (
    .ff_tx_clk(clk), .ff_tx_rst_n(rst_n), .s0(t0), .s1(t1),
    .ff_tx_data(t_data), .ff_tx_sop(t_sop), .ff_tx_eop(t_eop), .ff_tx_err(t_err),
    .ff_tx_wren(t_wren), .ff_tx_mod(t_mod), .ff_tx_rdy(mac_rdy),
    .pkt_cnt0(t_pc0), .pkt_cnt1(t_pc1), .trunc_cnt(t_tc)
  );

  int    checks = 0;
  int    failures = 0;
  int    wr_cnt = 0;
  beat_t qm[$];
  beat_t qt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // which: 0 = main DUT queue, 1 = 8-word DUT queue
  task automatic push_pkt(input int which, input int n, input logic [31:0] base,
                          input logic [1:0] mod, input int lim, input int npush);
    beat_t b;
    for (int i = 0; i < n && i < lim && i < npush; i++) begin
      b.d   = base + 32'(i);
      b.sop = (i == 0);
      b.eop = (i == n - 1) || (i == lim - 1);
      b.mod = (i == n - 1) ? mod : 2'b00;
      b.err = (i == lim - 1) && (i != n - 1);
      if (which == 0) qm.push_back(b);
      else            qt.push_back(b);
    end
  endtask

  task automatic set_src(input int s, input logic v, input logic [31:0] d,
                         input logic so, input logic eo, input logic [1:0] m);
    case (s)
      0: begin a0.valid = v; a0.data = d; a0.sop = so; a0.eop = eo; a0.mod = m; end
      1: begin a1.valid = v; a1.data = d; a1.sop = so; a1.eop = eo; a1.mod = m; end
      default: begin t0.valid = v; t0.data = d; t0.sop = so; t0.eop = eo; t0.mod = m; end
    endcase
  endtask

  function automatic logic get_rdy(input int s);
    case (s)
      0: return a0.ready;
      1: return a1.ready;
      default: return t0.ready;
    endcase
  endfunction

  // Source s = 2 drives source 0 of the 8-word DUT. mod is presented on every word.
  task automatic send(input int s, input int n, input logic [31:0] base,
                      input logic [1:0] mod, input int nsend);
    logic acc;
    int   guard;
    for (int i = 0; i < nsend; i++) begin
      set_src(s, 1'b1, base + 32'(i), i == 0, i == n - 1, mod);
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 500) begin
        @(negedge clk);
        acc = get_rdy(s);
        @(posedge clk);
        #1;
        guard++;
      end
      if (!acc) begin
        checks++;
        failures++;
        $display("FAIL send_timeout src=%0d word=%0d", s, i);
        break;
      end
    end
    set_src(s, 1'b0, 32'd0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((qm.size() != 0 || qt.size() != 0) && g < 2000) begin
      @(posedge clk);
      g++;
    end
    if (qm.size() != 0 || qt.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout qm=%0d qt=%0d", qm.size(), qt.size());
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (m_wren && mac_rdy) begin
      wr_cnt++;
      if (qm.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL main_unexpected_write actual=%0h", m_data);
      end else begin
        chk("main_beat", {m_data, m_sop, m_eop, m_mod, m_err}, qm.pop_front());
      end
    end
    if (t_wren && mac_rdy) begin
      if (qt.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL trunc_unexpected_write actual=%0h", t_data);
      end else begin
        chk("trunc_beat", {t_data, t_sop, t_eop, t_mod, t_err}, qt.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    checks++;
    failures++;
    $display("FAIL watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int w0;
    int g;
    set_src(0, 1'b0, 32'd0, 1'b0, 1'b0, 2'b00);
    set_src(1, 1'b0, 32'd0, 1'b0, 1'b0, 2'b00);
    set_src(2, 1'b0, 32'd0, 1'b0, 1'b0, 2'b00);
    t1.valid = 1'b0; t1.data = 32'd0; t1.sop = 1'b0; t1.eop = 1'b0; t1.mod = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {m_data, m_sop, m_eop, m_err, m_wren, m_mod}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_outputs", {m_data, m_sop, m_eop, m_err, m_wren, m_mod, a0.ready, a1.ready}, 64'd0);
    chk("post_rst_counters", {m_pc0, m_pc1, m_tc, t_tc}, 64'd0);

    // Simultaneous requests: source 0 first, then source 1, twice over
    for (int k = 0; k < 2; k++) begin
      automatic logic [31:0] ba = 32'hA000_0000 + 32'(k * 16);
      automatic logic [31:0] bb = 32'hB000_0000 + 32'(k * 16);
      push_pkt(0, 4, ba, 2'd1, 380, 4);
      push_pkt(0, 4, bb, 2'd2, 380, 4);
      fork
        send(0, 4, ba, 2'd1, 4);
        send(1, 4, bb, 2'd2, 4);
      join
      wait_drain();
      chk("tie_pkt_cnt0", m_pc0, 64'(k + 1));
      chk("tie_pkt_cnt1", m_pc1, 64'(k + 1));
    end

    push_pkt(0, 16, 32'h1000_0000, 2'd2, 380, 16);
    send(0, 16, 32'h1000_0000, 2'd2, 16);
    wait_drain();
    chk("pkt16_pkt_cnt0", m_pc0, 64'd3);

    // MAC back-pressure for 20 cycles while word 4 is on the bus
    w0 = wr_cnt;
    push_pkt(0, 10, 32'hC000_0000, 2'd3, 380, 10);
    fork
      send(0, 10, 32'hC000_0000, 2'd3, 10);
      begin
        g = 0;
        while (wr_cnt < w0 + 4 && g < 500) begin
          @(posedge clk);
          g++;
        end
        chk("stall_reached", 64'(wr_cnt >= w0 + 4), 64'd1);
        #1;
        mac_rdy = 1'b0;
        repeat (20) begin
          @(negedge clk);
          chk("stall_hold", {m_wren, m_data, a0.ready}, {1'b1, 32'hC000_0004, 1'b0});
        end
        @(posedge clk);
        #1;
        mac_rdy = 1'b1;
      end
    join
    wait_drain();
    chk("stall_pkt_cnt0", m_pc0, 64'd4);

    push_pkt(0, 1, 32'hE000_0001, 2'd3, 380, 1);
    send(1, 1, 32'hE000_0001, 2'd3, 1);
    wait_drain();
    chk("single_pkt_cnt1", m_pc1, 64'd3);

    push_pkt(1, 12, 32'hD000_0000, 2'd2, 8, 12);
    send(2, 12, 32'hD000_0000, 2'd2, 12);
    wait_drain();
    chk("trunc_cnt", t_tc, 64'd1);
    chk("trunc_pkt_cnt0", t_pc0, 64'd0);

    // Reset asserted with a word pending mid-packet
    push_pkt(0, 8, 32'hF000_0000, 2'd0, 380, 3);
    send(0, 8, 32'hF000_0000, 2'd0, 3);
    mac_rdy = 1'b0;
    set_src(0, 1'b1, 32'hF000_0003, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    chk("pre_rst_wren", m_wren, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {m_data, m_sop, m_eop, m_err, m_wren, m_mod, a0.ready}, 64'd0);
    chk("async_rst_counters", {m_pc0, m_pc1, m_tc}, 64'd0);
    set_src(0, 1'b0, 32'd0, 1'b0, 1'b0, 2'b00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mac_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_queue_empty", 64'(qm.size()), 64'd0);
    push_pkt(0, 4, 32'h5000_0000, 2'd1, 380, 4);
    send(0, 4, 32'h5000_0000, 2'd1, 4);
    wait_drain();
    chk("recover_pkt_cnt0", m_pc0, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_tx_arbiter.md
# mac_tx_arbiter

Packet-level arbiter sharing the MAC transmit FIFO write interface (ff_tx_* Avalon-ST, 32-bit, big-endian byte lanes) between two packet sources: source 0 carries sample-stream UDP frames and source 1 carries control/ARP frames. Sources are granted whole packets in round-robin order. Oversized packets are truncated and flagged with ff_tx_err. Per-source statistics counters are provided. The block sits between the packet builders and the MAC core's ff_tx port.

## Interface
- MAX_WORDS, 380: maximum 32-bit words per packet (1518 bytes / 4, rounded up); the counter width is derived from it.
- ff_tx_clk  in  1  MAC TX FIFO clock; sole clock.
- ff_tx_rst_n  in  1  reset, asynchronous assert, active-low.
- s0_data / s1_data  in  32  source data; byte 0 is on [31:24].
- s0_sop / s1_sop  in  1  first word of packet.
- s0_eop / s1_eop  in  1  last word of packet.
- s0_mod / s1_mod  in  2  empty bytes in the eop word (00 means 4 valid bytes, 11 means 1); ignored when eop=0.
- s0_valid / s1_valid  in  1  source has a word.
- s0_ready / s1_ready  out  1  word accepted when valid && ready.
- ff_tx_data  out  32  to MAC.
- ff_tx_sop, ff_tx_eop, ff_tx_err, ff_tx_wren  out  1  to MAC.
- ff_tx_mod  out  2  to MAC.
- ff_tx_rdy  in  1  MAC can accept; a MAC write occurs when wren && rdy.
- pkt_cnt0 / pkt_cnt1  out  16  packets completed per source; wrap at 0xFFFF→0.
- trunc_cnt  out  8  truncated packets (both sources); saturates at 0xFF.

## Operation
- FSM states: IDLE, FWD, DRAIN.
- **IDLE**
  - A request is valid && sop. Non-sop valid words are never granted; that source stalls (protocol error).
  - If exactly one request is present: grant it.
  - If both are present: grant the source that is not last_grant. last_grant resets to 1, so source 0 wins the first tie.
  - On grant: register grant and last_grant, clear word_cnt, set first=1, go to FWD.
  - s*_ready = 0 and ff_tx_wren = 0 in IDLE.
- **FWD** (combinational pass-through from the granted source g)
  - ff_tx_data = sg_data.
  - ff_tx_wren = sg_valid.
  - sg_ready = ff_tx_rdy. The other source's ready = 0.
  - ff_tx_sop = first. A source sop on later words is ignored.
  - ff_tx_eop = sg_eop || limit, where limit = (word_cnt == MAX_WORDS-1).
  - ff_tx_mod = sg_mod when sg_eop, else 00.
  - ff_tx_err = limit && !sg_eop.
  - On each transfer: word_cnt++ and first cleared.
  - Transfer with sg_eop: increment pkt_cntg, go to IDLE.
  - Transfer with limit && !sg_eop: increment trunc_cnt (saturating), go to DRAIN.
- **DRAIN**
  - sg_ready = 1 and ff_tx_wren = 0; source words are discarded.
  - A transfer with sg_eop returns to IDLE. pkt_cnt is not incremented.
- Simultaneous sop and eop (single-word packet): one MAC write with sop=eop=1, then IDLE.
- All outputs are 0 in reset. FSM resets to IDLE, counters to 0, last_grant to 1.
- Reset asserted mid-packet: the MAC sees wren drop immediately. No eop is generated; recovery of the MAC is outside this block.

## Timing
- Grant latency: 1 cycle. A request seen in IDLE at edge N gives the first MAC write possible in cycle N+1.
- Inter-packet gap: 1 IDLE cycle after every eop, so back-to-back packets take length+1 cycles minimum.
- Zero-latency datapath in FWD: the data, control and ready paths are combinational through the grant mux.
- ff_tx_rdy low holds the current word. The source keeps its data per the valid/ready rule, and word_cnt, first and the FSM do not change.
- Counters update on the edge ending the eop or truncation transfer. They are visible in the next cycle.
- Truncation fires on word index MAX_WORDS-1, i.e. the MAX_WORDS-th word. A packet of exactly MAX_WORDS words ending with its own eop is not truncated.

## Structure
- Shared package mac_tx_pkg holds:
  - state enum {IDLE, FWD, DRAIN}
  - MOD_4B=2'b00 … MOD_1B=2'b11 constants
  - MAX_WORDS_DEFAULT=380
  - word-counter width function
- One natural sub-module: rr_arb2, a 2-way round-robin pick with registered last_grant. The grant mux, FSM and counters live in mac_tx_arbiter.

## Test plan
- Single source 0, 16-word packet, ff_tx_rdy=1: 16 MAC writes, sop on word 0, eop+mod on word 15; pkt_cnt0=1; then 1 idle cycle.
- Both sources request in the same cycle after reset, 4 words each: source 0 packet first, then source 1. The next tie grants source 0 again. No interleaving of words.
- ff_tx_rdy low for 20 cycles mid-packet: wren stays on with the data held; the MAC captures an identical byte sequence; word_cnt is unchanged.
- MAX_WORDS=8, source sends 12 words: MAC sees 8 writes, the 8th with eop=1, err=1, mod=00; remaining 4 words are drained; trunc_cnt=1; pkt_cnt unchanged.
- Single-word packet (sop=eop=1, mod=11): one write with sop=eop=1, mod=11.
- Reset pulled low during FWD: all outputs go to 0 asynchronously. After release, a new packet forwards normally.
